// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall unit.
// Optional perf counters are enabled with the HAZARD_PERF_CNT_EN macro.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         CNT_W    = 3;

endpackage

// File: rtl/hazard_detect_cmp.sv
// Combinational load-use compare between a load destination and the ID-stage sources.
// Kept separate so branch-operand hazard checks can reuse it.
module hazard_detect_cmp
    import hazard_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] dest,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rs,
    input  logic       uses_rt,
    output logic       hit
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hit = mem_read && (dest != REG_ZERO) &&
                 ((uses_rs && (dest == rs)) || (uses_rt && (dest == rt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, memory freeze and branch flushes.
// Define HAZARD_PERF_CNT_EN to build the StallCycles/FlushCount counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int BRANCH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRs,
    input  logic        IFID_UsesRt,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        BranchTaken,
    input  logic        MemBusy,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        PipeWrite,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);

    localparam logic [CNT_W-1:0] LU_INIT = (LOAD_LAT > 1)     ? CNT_W'(LOAD_LAT - 2)     : '0;
    localparam logic [CNT_W-1:0] BR_INIT = (BRANCH_SLOTS > 1) ? CNT_W'(BRANCH_SLOTS - 2) : '0;

    hz_state_t        state, resume_state, eff_state;
    logic [CNT_W-1:0] cnt, resume_cnt, eff_cnt;
    logic             hz;

    hazard_detect_cmp u_cmp (
        .mem_read (IDEX_MemRead),
        .dest     (IDEX_Rt),
        .rs       (IFID_Rs),
        .rt       (IFID_Rt),
        .uses_rs  (IFID_UsesRs),
        .uses_rt  (IFID_UsesRt),
        .hit      (hz)
    );

    // Leaving MEM_WAIT behaves exactly like the saved state in that same cycle
    assign eff_state = (state == MEM_WAIT) ? resume_state : state;
    assign eff_cnt   = (state == MEM_WAIT) ? resume_cnt   : cnt;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        PipeWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (!rst) begin
            if (MemBusy) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                PipeWrite = 1'b0;
            end else begin
                case (eff_state)
                    RUN: begin
                        if (hz) begin
                            PCWrite    = 1'b0;
                            IFIDWrite  = 1'b0;
                            IDEXBubble = 1'b1;
                        end else if (BranchTaken) begin
                            IFIDFlush = 1'b1;
                        end
                    end
                    LU_STALL: begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                    REDIRECT: IFIDFlush = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            resume_state <= RUN;
            resume_cnt   <= '0;
        end else if (MemBusy) begin
            if (state != MEM_WAIT) begin
                resume_state <= state;
                resume_cnt   <= cnt;
                state        <= MEM_WAIT;
            end
        end else begin
            state <= eff_state;
            cnt   <= eff_cnt;
            case (eff_state)
                RUN: begin
                    if (hz) begin
                        if (LOAD_LAT > 1) begin
                            state <= LU_STALL;
                            cnt   <= LU_INIT;
                        end
                    end else if (BranchTaken && (BRANCH_SLOTS > 1)) begin
                        state <= REDIRECT;
                        cnt   <= BR_INIT;
                    end
                end
                LU_STALL, REDIRECT: begin
                    if (eff_cnt == '0) state <= RUN;
                    else               cnt   <= eff_cnt - CNT_W'(1);
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    logic        start_flush;

    assign start_flush = !rst && !MemBusy && (eff_state == RUN) && !hz && BranchTaken;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PCWrite)    stall_q <= stall_q + 32'd1;
            if (start_flush) flush_q <= flush_q + 32'd1;
        end
    end

    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit; dut_a uses LOAD_LAT=3/BRANCH_SLOTS=2,
// dut_b uses LOAD_LAT=1/BRANCH_SLOTS=1. Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeWrite}
    localparam logic [4:0] DEF    = 5'b11001;
    localparam logic [4:0] STALL  = 5'b00011;
    localparam logic [4:0] FROZEN = 5'b00000;
    localparam logic [4:0] FLUSH  = 5'b11101;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       uses_rs, uses_rt, mem_read, branch_taken, mem_busy;

    logic        pcw_a, ifw_a, fl_a, bub_a, pw_a;
    logic        pcw_b, ifw_b, fl_b, bub_b, pw_b;
    logic [31:0] stall_a, flushc_a, stall_b, flushc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_LAT(3), .BRANCH_SLOTS(2)) dut_a (
        .clk(clk), .rst(rst),
        .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_UsesRs(uses_rs), .IFID_UsesRt(uses_rt),
        .IDEX_MemRead(mem_read), .IDEX_Rt(idex_rt), .BranchTaken(branch_taken), .MemBusy(mem_busy),
        .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(fl_a), .IDEXBubble(bub_a), .PipeWrite(pw_a),
        .StallCycles(stall_a), .FlushCount(flushc_a)
    );

    hazard_stall_unit #(.LOAD_LAT(1), .BRANCH_SLOTS(1)) dut_b (
        .clk(clk), .rst(rst),
        .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_UsesRs(uses_rs), .IFID_UsesRt(uses_rt),
        .IDEX_MemRead(mem_read), .IDEX_Rt(idex_rt), .BranchTaken(branch_taken), .MemBusy(mem_busy),
        .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(fl_b), .IDEXBubble(bub_b), .PipeWrite(pw_b),
        .StallCycles(stall_b), .FlushCount(flushc_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples both DUTs mid-cycle, then advances to just after the next rising edge
    task automatic check_output(input string tag, input logic [4:0] exp_a, input logic [4:0] exp_b);
        @(negedge clk);
        check({tag, "_a"}, {27'd0, pcw_a, ifw_a, fl_a, bub_a, pw_a}, {27'd0, exp_a});
        check({tag, "_b"}, {27'd0, pcw_b, ifw_b, fl_b, bub_b, pw_b}, {27'd0, exp_b});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
        uses_rs = 1'b0; uses_rt = 1'b0; mem_read = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use_rs5();
        mem_read = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; uses_rs = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] hazard_stall_unit directed test, perf counters %0d", PERF);
        clear_inputs();
        rst = 1'b1;
        mem_busy = 1'b1;
        load_use_rs5();
        check_output("reset_forced", DEF, DEF);
        clear_inputs();
        rst = 1'b0;
        check("reset_stallcnt", stall_a, 32'd0);
        check("reset_flushcnt", flushc_a, 32'd0);

        // Load-use on Rs
        load_use_rs5();
        check_output("lu_rs_c1", STALL, STALL);
        mem_read = 1'b0;
        check_output("lu_rs_c2", STALL, DEF);
        check_output("lu_rs_c3", STALL, DEF);
        check_output("lu_rs_done", DEF, DEF);
        check("lu_rs_stall_a", stall_a, PERF ? 32'd3 : 32'd0);
        check("lu_rs_stall_b", stall_b, PERF ? 32'd1 : 32'd0);

        // False hazards: r0, and Rt match without UsesRt
        mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        uses_rs = 1'b1; uses_rt = 1'b1;
        check_output("false_r0", DEF, DEF);
        idex_rt = 5'd5; ifid_rs = 5'd7; ifid_rt = 5'd5; uses_rt = 1'b0;
        check_output("false_nouse_rt", DEF, DEF);
        uses_rt = 1'b1;
        check_output("lu_rt_c1", STALL, STALL);
        mem_read = 1'b0;
        check_output("lu_rt_c2", STALL, DEF);
        check_output("lu_rt_c3", STALL, DEF);
        check_output("lu_rt_done", DEF, DEF);

        // LOAD_LAT=3 with a 4-cycle memory freeze in the second stall cycle
        do_reset();
        check("rst2_stall_a", stall_a, 32'd0);
        load_use_rs5();
        check_output("mw_c1", STALL, STALL);
        mem_read = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) check_output("mw_frozen", FROZEN, FROZEN);
        mem_busy = 1'b0;
        check_output("mw_resume1", STALL, DEF);
        check_output("mw_resume2", STALL, DEF);
        check_output("mw_done", DEF, DEF);
        check("mw_stall_a", stall_a, PERF ? 32'd7 : 32'd0);
        check("mw_stall_b", stall_b, PERF ? 32'd5 : 32'd0);

        // Simultaneous hazard and branch: stall wins
        do_reset();
        load_use_rs5();
        branch_taken = 1'b1;
        check_output("hzbr_c1", STALL, STALL);
        mem_read = 1'b0;
        check_output("hzbr_c2", STALL, FLUSH);
        branch_taken = 1'b0;
        check("hzbr_flush_b", flushc_b, PERF ? 32'd1 : 32'd0);
        check("hzbr_flush_a", flushc_a, 32'd0);
        check_output("hzbr_c3", STALL, DEF);
        check_output("hzbr_done", DEF, DEF);

        // Branch held high for three cycles
        do_reset();
        branch_taken = 1'b1;
        check_output("br_c1", FLUSH, FLUSH);
        check_output("br_c2", FLUSH, FLUSH);
        check_output("br_c3_new", FLUSH, FLUSH);
        branch_taken = 1'b0;
        check_output("br_c4", FLUSH, DEF);
        check_output("br_done", DEF, DEF);
        check("br_flush_a", flushc_a, PERF ? 32'd2 : 32'd0);
        check("br_flush_b", flushc_b, PERF ? 32'd3 : 32'd0);

        // Reset in the middle of a load-use stall
        do_reset();
        load_use_rs5();
        check_output("rstmid_c1", STALL, STALL);
        mem_read = 1'b0;
        check_output("rstmid_c2", STALL, DEF);
        rst = 1'b1;
        check_output("rstmid_forced", DEF, DEF);
        rst = 1'b0;
        check("rstmid_stall_a", stall_a, 32'd0);
        check("rstmid_stall_b", stall_b, 32'd0);
        check_output("rstmid_run", DEF, DEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side counterpart of the EX-stage forwarding logic; controls the pipeline where forwarding cannot resolve a hazard.
- Detects load-use hazards between the IF/ID instruction and a load in ID/EX, and inserts bubbles.
- Freezes the whole pipeline while data memory is busy, and flushes fetch slots on a taken branch.
- Sits beside the IF/ID and ID/EX registers and drives PC and pipeline-register write enables.

Parameters:
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
- BRANCH_SLOTS, 1, IF/ID flush cycles per taken branch (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- IFID_Rs  in  5  source register Rs of the instruction in ID
- IFID_Rt  in  5  source register Rt of the instruction in ID
- IFID_UsesRs  in  1  ID instruction reads Rs
- IFID_UsesRt  in  1  ID instruction reads Rt
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_Rt  in  5  load destination register
- BranchTaken  in  1  ID-stage branch resolved taken
- MemBusy  in  1  data memory has not completed its access this cycle
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  zero the IF/ID register
- IDEXBubble  out  1  load NOP controls into ID/EX
- PipeWrite  out  1  ID/EX, EX/MEM and MEM/WB enable
- StallCycles  out  32  stall-cycle counter (see Optional Feature)
- FlushCount  out  32  branch-flush counter (see Optional Feature)

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- FSM states: RUN, LU_STALL, MEM_WAIT, REDIRECT.
- Registered state: 3-bit cnt and a resume register {state, cnt}.
- Outputs are combinational from state and inputs, so they take effect in the same cycle.
- Reset: state=RUN, cnt=0, resume=RUN/0. While rst=1 outputs are forced to PCWrite=1, IFIDWrite=1, PipeWrite=1, IFIDFlush=0, IDEXBubble=0.
- Reset mid-stall or mid-wait abandons the operation immediately.
- Default outputs: PCWrite=1, IFIDWrite=1, PipeWrite=1, IFIDFlush=0, IDEXBubble=0.
- hz (load-use hazard) = IDEX_MemRead && IDEX_Rt!=0 && ((IFID_UsesRs && IDEX_Rt==IFID_Rs) || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- Priority, in every state: MemBusy, then hz/LU_STALL, then BranchTaken.
- MemBusy=1 in any state:
  - All enables 0 (PCWrite, IFIDWrite, PipeWrite); no bubble, no flush.
  - On entry from another state, save {state, cnt} into resume; go to MEM_WAIT.
- MEM_WAIT: hold all enables 0. When MemBusy=0, return to the saved state with cnt unchanged; that same cycle uses that state's outputs.
- RUN with hz=1:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - If LOAD_LAT>1: go to LU_STALL with cnt=LOAD_LAT-2. If LOAD_LAT=1: stay in RUN.
  - BranchTaken is ignored that cycle, because the ID operands are not yet valid.
- LU_STALL: same outputs as a RUN hz cycle. When cnt==0 go to RUN, else decrement cnt. BranchTaken is ignored.
- RUN with BranchTaken=1 and hz=0:
  - IFIDFlush=1, PCWrite=1.
  - If BRANCH_SLOTS>1: go to REDIRECT with cnt=BRANCH_SLOTS-2.
- REDIRECT: IFIDFlush=1. When cnt==0 go to RUN, else decrement. A new BranchTaken in REDIRECT is ignored, because flushed slots cannot branch.
- Register 0 never causes a hazard.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - StallCycles increments every cycle with PCWrite=0.
  - FlushCount increments on each RUN cycle that starts a branch flush.
  - Both are 32-bit, wrap at 2^32-1 to 0, and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hazard_pkg:
  - hz_state_t enum (RUN, LU_STALL, MEM_WAIT, REDIRECT).
  - REG_ZERO=5'd0.
  - CNT_W=3.
- Sub-module hazard_detect_cmp: combinational hz compare, reused by future branch-operand hazard checks.

Test Plan:
- Load-use on Rs: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5, IFID_UsesRs=1, LOAD_LAT=1 -> one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1, then defaults.
- False hazards: IDEX_Rt=0 with IFID_Rs=0, and IDEX_Rt=5 with IFID_Rt=5 but IFID_UsesRt=0 -> no stall.
- LOAD_LAT=3 stall with MemBusy=1 for 4 cycles in the 2nd stall cycle:
  - 4 frozen cycles (all enables 0).
  - Then exactly 2 more bubble cycles, for 3 bubbles total.
  - With the feature on, StallCycles=7.
- Simultaneous hz and BranchTaken -> stall only, IFIDFlush=0; on the next cycle, BranchTaken=1 -> IFIDFlush=1, FlushCount=1.
- BRANCH_SLOTS=2 with BranchTaken held high 3 cycles -> IFIDFlush high 2 cycles; 3rd cycle starts a new flush.
- rst asserted mid-LU_STALL -> next cycle defaults, state RUN; counters 0 with the feature on.
